// File: rtl/pwm_pkg.sv
// Shared PWM definitions: counter width, timeout,
// capture FSM states and the edge-detector bundle.
package pwm_pkg;

  localparam int CNT_W_DEF       = 28;
  localparam int SYNC_STAGES_DEF = 2;
  localparam int TIMEOUT_DEF     = 50000000;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    ARMED_HIGH = 2'd1,
    ARMED_LOW  = 2'd2
  } cap_state_e;

  typedef struct packed {
    logic sync;
    logic rise;
    logic fall;
  } edge_t;

endpackage

// File: rtl/pwm_edge_sync.sv
// Pin synchronizer plus history flop; emits the
// synchronized level and single-cycle rise/fall strobes.
module pwm_edge_sync
  import pwm_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic  CLK,
  input  logic  RST_N,
  input  logic  pwm_in,
  output edge_t edges
);

  logic [SYNC_STAGES-1:0] sff;
  logic                   prev;
  logic                   sync;

  assign sync = sff[SYNC_STAGES-1];

  // Shift the pin through the chain, then keep one
  // cycle of history so both edges see equal latency.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      sff  <= '0;
      prev <= 1'b0;
    end else begin
      sff  <= {sff[SYNC_STAGES-2:0], pwm_in};
      prev <= sync;
    end
  end

  // Edge strobes from the synchronized level.
  always_comb begin
    edges.sync = sync;
    edges.rise = sync & ~prev;
    edges.fall = ~sync & prev;
  end

endmodule

// File: rtl/pwm_capture.sv
// PWM capture: measures period and high time in CLK
// cycles and flags a line that stopped toggling.
module pwm_capture
  import pwm_pkg::*;
#(
  parameter int CNT_W          = CNT_W_DEF,
  parameter int SYNC_STAGES    = SYNC_STAGES_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEF
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             pwm_in,
  input  logic             enable,
  output logic [CNT_W-1:0] period_out,
  output logic [CNT_W-1:0] decode_out,
  output logic             meas_valid,
  output logic             static_out,
  output logic             static_level
);

  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CMAX = '1;
  localparam logic [CNT_W-1:0] TMO  =
    CNT_W'(TIMEOUT_CYCLES);

  edge_t edges;

  cap_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cnt_inc;
  logic [CNT_W-1:0] high_q, high_d;
  logic [CNT_W-1:0] per_q, per_d;
  logic [CNT_W-1:0] dec_q, dec_d;
  logic             mv_q, mv_d;
  logic             st_q, st_d;
  logic             sl_q, sl_d;
  logic             any_edge;

  pwm_edge_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .CLK    (CLK),
    .RST_N  (RST_N),
    .pwm_in (pwm_in),
    .edges  (edges)
  );

  assign any_edge = edges.rise | edges.fall;
  assign cnt_inc  = (cnt_q == CMAX) ? cnt_q
                                    : cnt_q + ONE;

  // State and result registers.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      high_q  <= '0;
      per_q   <= '0;
      dec_q   <= '0;
      mv_q    <= 1'b0;
      st_q    <= 1'b0;
      sl_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      high_q  <= high_d;
      per_q   <= per_d;
      dec_q   <= dec_d;
      mv_q    <= mv_d;
      st_q    <= st_d;
      sl_q    <= sl_d;
    end
  end

  // Next-state: arm on rise, latch high time on
  // fall, publish on the following rise; an edge
  // always beats a coincident timeout.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_inc;
    high_d  = high_q;
    per_d   = per_q;
    dec_d   = dec_q;
    mv_d    = 1'b0;
    st_d    = st_q;
    sl_d    = sl_q;
    if (!enable) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      if (st_q && any_edge)
        st_d = 1'b0;
      unique case (state_q)
        IDLE: begin
          cnt_d = '0;
          if (edges.rise) begin
            state_d = ARMED_HIGH;
            cnt_d   = ONE;
          end
        end
        ARMED_HIGH: begin
          if (edges.fall) begin
            high_d  = cnt_q;
            state_d = ARMED_LOW;
          end else if (!any_edge && cnt_q >= TMO) begin
            per_d   = '0;
            dec_d   = '0;
            st_d    = 1'b1;
            sl_d    = edges.sync;
            cnt_d   = '0;
            state_d = IDLE;
          end
        end
        ARMED_LOW: begin
          if (edges.rise) begin
            per_d   = cnt_q;
            dec_d   = high_q;
            mv_d    = 1'b1;
            cnt_d   = ONE;
            state_d = ARMED_HIGH;
          end else if (!any_edge && cnt_q >= TMO) begin
            per_d   = '0;
            dec_d   = '0;
            st_d    = 1'b1;
            sl_d    = edges.sync;
            cnt_d   = '0;
            state_d = IDLE;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  assign period_out   = per_q;
  assign decode_out   = dec_q;
  assign meas_valid   = mv_q;
  assign static_out   = st_q;
  assign static_level = sl_q;

endmodule
